// File: rtl/mem_arb_pkg.sv
// Shared types and the arbitration pick function for the memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VID  = 2'd2
  } owner_e;

  // Chooses the next owner from the current-cycle requests. cpu_first breaks
  // the tie when both request; the caller decides what that means (starvation
  // bound reached, or video won last time in round-robin mode).
  function automatic owner_e pick_owner(input logic cpu_req,
                                        input logic vid_req,
                                        input logic cpu_first);
    if (cpu_req && vid_req) return cpu_first ? OWN_CPU : OWN_VID;
    else if (cpu_req)       return OWN_CPU;
    else if (vid_req)       return OWN_VID;
    else                    return OWN_NONE;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one memory port between the CPU and the video fetcher.
// One access at a time: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> ACK -> IDLE.
// Default: video wins ties, but after STARVE_MAX consecutive video wins with
// the CPU waiting, the CPU is forced through.
// Define ARB_ROUND_ROBIN_EN to replace that with strict alternation on ties
// (the starvation counter is then not built).
// Handshake: a requester holds req (plus addr/we/wdata) high until it sees its
// one-cycle ack; req high while the FSM is in IDLE is treated as a new request,
// and a req dropped mid-access does not abort the access.
// dbg_state mirrors the FSM state for checkers.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  localparam int LW = $clog2(MEM_LAT + 1);
  localparam logic [LW-1:0] LAT_INIT = LW'(MEM_LAT);
  localparam logic [LW-1:0] LAT_LAST = LW'(1);

  state_e          state;
  owner_e          owner;
  logic            own_we;
  logic [LW-1:0]   lat_cnt;
  logic            cpu_first;
  owner_e          pick;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e          last_grant;

  // Tie-break: whoever won last time loses this time.
  always_comb begin
    cpu_first = (last_grant == OWN_VID);
    pick      = pick_owner(cpu_req, vid_req, cpu_first);
  end
`else
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  logic [SW-1:0]   starve_cnt;

  // Tie-break: video, unless the CPU has been passed over STARVE_MAX times.
  always_comb begin
    cpu_first = (starve_cnt == STARVE_TOP);
    pick      = pick_owner(cpu_req, vid_req, cpu_first);
  end
`endif

  assign dbg_state = state;

  // Access sequencer: arbitration, memory strobe, latency count, data capture, ack.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      own_we     <= 1'b0;
      lat_cnt    <= '0;
      cpu_ack    <= 1'b0;
      vid_ack    <= 1'b0;
      cpu_rdata  <= '0;
      vid_rdata  <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= OWN_NONE;
`else
      starve_cnt <= '0;
`endif
    end else begin
      // Strobes and memory-side outputs are only live for one cycle each.
      cpu_ack   <= 1'b0;
      vid_ack   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      case (state)
        IDLE: begin
          if (pick != OWN_NONE) begin
            owner  <= pick;
            state  <= ISSUE;
            mem_en <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= pick;
`endif
            if (pick == OWN_CPU) begin
              own_we    <= cpu_we;
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
`ifndef ARB_ROUND_ROBIN_EN
              starve_cnt <= '0;
`endif
            end else begin
              own_we    <= 1'b0;
              mem_addr  <= vid_addr;
`ifndef ARB_ROUND_ROBIN_EN
              if (cpu_req && (starve_cnt != STARVE_TOP))
                starve_cnt <= starve_cnt + 1'b1;
`endif
            end
          end
        end
        ISSUE: begin
          lat_cnt <= LAT_INIT;
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            state <= ACK;
            if (!own_we) begin
              if (owner == OWN_CPU) cpu_rdata <= mem_rdata;
              if (owner == OWN_VID) vid_rdata <= mem_rdata;
            end
            cpu_ack <= (owner == OWN_CPU);
            vid_ack <= (owner == OWN_VID);
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ACK: begin
          state <= IDLE;
          owner <= OWN_NONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MEM_LAT=2, STARVE_MAX=3).
// The memory model returns ~addr[7:0] two cycles after mem_en.
module tb_mem_arbiter;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b1;
  logic        cpu_req  = 1'b0;
  logic        cpu_we   = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        vid_req  = 1'b0;
  logic [15:0] vid_addr = '0;
  logic        vid_ack;
  logic [7:0]  vid_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [1:0]  dbg_state;

  int vectors    = 0;
  int miscompares = 0;

  // clock / reset block
  always #10 CLOCK_50 = ~CLOCK_50;

  // Memory model: two-stage address pipeline, data = ~addr[7:0].
  logic [15:0] p1 = '0;
  logic [15:0] p2 = '0;
  always @(posedge CLOCK_50) begin
    p1 <= mem_addr;
    p2 <= p1;
  end
  assign mem_rdata = ~p2[7:0];

  mem_arbiter #(.ADDR_W(16), .DATA_W(8), .MEM_LAT(2), .STARVE_MAX(3)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ack  (cpu_ack),
    .cpu_rdata(cpu_rdata),
    .vid_req  (vid_req),
    .vid_addr (vid_addr),
    .vid_ack  (vid_ack),
    .vid_rdata(vid_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample and drive 1 time unit after the edge.
  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  // 1 = video ack, 2 = cpu ack
  int exp_order [5];
  int got;
  int which;

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1, 2, 1, 2, 1};
`else
    exp_order = '{1, 1, 1, 2, 1};
`endif

    // ---------------- reset state
    repeat (3) step();
    check("rst_state",     dbg_state, 0);
    check("rst_cpu_ack",   cpu_ack,   0);
    check("rst_vid_ack",   vid_ack,   0);
    check("rst_mem_en",    mem_en,    0);
    check("rst_mem_addr",  mem_addr,  0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_vid_rdata", vid_rdata, 0);
    reset = 1'b0;
    step();

    // ---------------- 1: CPU read 0x1234 alone
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    check("t1_c0_mem_en", mem_en, 0);
    step();
    check("t1_c1_mem_en",   mem_en,   1);
    check("t1_c1_mem_we",   mem_we,   0);
    check("t1_c1_mem_addr", mem_addr, 16'h1234);
    step();
    check("t1_c2_mem_en",  mem_en,  0);
    check("t1_c2_cpu_ack", cpu_ack, 0);
    step();
    check("t1_c3_cpu_ack", cpu_ack, 0);
    step();
    check("t1_c4_cpu_ack",   cpu_ack,   1);
    check("t1_c4_vid_ack",   vid_ack,   0);
    check("t1_c4_cpu_rdata", cpu_rdata, 8'hCB);
    cpu_req = 1'b0;
    step();
    check("t1_c5_cpu_ack",   cpu_ack,   0);
    check("t1_c5_rdata_hold", cpu_rdata, 8'hCB);

    // ---------------- 2: CPU write 0x0010 <- 0xA5
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'hA5;
    step();
    check("t2_c1_mem_en",    mem_en,    1);
    check("t2_c1_mem_we",    mem_we,    1);
    check("t2_c1_mem_addr",  mem_addr,  16'h0010);
    check("t2_c1_mem_wdata", mem_wdata, 8'hA5);
    step();
    check("t2_c2_mem_wdata", mem_wdata, 0);
    step();
    step();
    check("t2_c4_cpu_ack",   cpu_ack,   1);
    check("t2_c4_cpu_rdata", cpu_rdata, 8'hCB);
    cpu_req = 1'b0; cpu_we = 1'b0;
    step();

    // ---------------- 3/4: both requesting continuously
    cpu_req = 1'b1; cpu_addr = 16'h0100;
    vid_req = 1'b1; vid_addr = 16'h0042;
    for (int g = 0; g < 5; g++) begin
      got = 0;
      which = 0;
      for (int t = 0; t < 10 && got == 0; t++) begin
        step();
        check("t3_ack_overlap", {31'd0, cpu_ack & vid_ack}, 0);
        if (cpu_ack || vid_ack) begin
          got = 1;
          which = vid_ack ? 1 : 2;
        end
      end
      check("t3_grant_seen",  got,   1);
      check("t3_grant_order", which, exp_order[g]);
      if (which == 1) check("t3_vid_rdata", vid_rdata, 8'hBD);
      if (which == 2) check("t3_cpu_rdata", cpu_rdata, 8'hFF);
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    step();

    // ---------------- 5: reset during WAIT of a CPU read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h00F0;
    step();
    check("t5_c1_mem_en", mem_en, 1);
    step();
    check("t5_c2_state", dbg_state, 2);
    reset = 1'b1; cpu_req = 1'b0;
    step();
    check("t5_c3_state",     dbg_state, 0);
    check("t5_c3_cpu_ack",   cpu_ack,   0);
    check("t5_c3_mem_en",    mem_en,    0);
    check("t5_c3_cpu_rdata", cpu_rdata, 0);
    reset = 1'b0;
    for (int t = 0; t < 2; t++) begin
      step();
      check("t5_no_ack", cpu_ack, 0);
      check("t5_idle",   dbg_state, 0);
    end

    // ---------------- 6: video drops req mid-access
    vid_req = 1'b1; vid_addr = 16'h5A5A;
    step();
    check("t6_c1_mem_en",   mem_en,   1);
    check("t6_c1_mem_we",   mem_we,   0);
    check("t6_c1_mem_addr", mem_addr, 16'h5A5A);
    step();
    vid_req = 1'b0;
    step();
    check("t6_c3_vid_ack", vid_ack, 0);
    step();
    check("t6_c4_vid_ack",   vid_ack,   1);
    check("t6_c4_cpu_ack",   cpu_ack,   0);
    check("t6_c4_vid_rdata", vid_rdata, 8'hA5);
    for (int t = 0; t < 4; t++) begin
      step();
      check("t6_no_second_en",  mem_en,  0);
      check("t6_no_second_ack", vid_ack, 0);
    end

    // ---------------- CPU read served normally after the reset
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h00F0;
    repeat (4) step();
    check("t7_c4_cpu_ack",   cpu_ack,   1);
    check("t7_c4_cpu_rdata", cpu_rdata, 8'h0F);
    cpu_req = 1'b0;
    step();
    check("t7_c5_cpu_ack", cpu_ack, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
